// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// One operation in flight at a time; writes take 2 cycles, reads return rsp_valid 3 cycles after accept.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  wr_enable,
  output logic                  rd_enable,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W-1:0]     data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   last_gnt;
  logic   owner;
  logic   op_we;
  logic   win;
  logic   [1:0] grant;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    win   = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
    grant = 2'b00;
    if (!rst && state == IDLE && req_valid != 2'b00) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      op_we     <= 1'b0;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      addr      <= '0;
      data_in   <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            last_gnt  <= win;
            owner     <= win;
            op_we     <= req_we[win];
            addr      <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            data_in   <= win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            wr_enable <= req_we[win];
            rd_enable <= ~req_we[win];
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wr_enable <= 1'b0;
          rd_enable <= 1'b0;
          if (op_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Memory output is valid the cycle after rd_enable.
          rsp_rdata <= data_out;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected memory ops and responses at accept time,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v_vld [2];
  logic          v_we  [2];
  logic [AW-1:0] v_addr[2];
  logic [DW-1:0] v_wd  [2];

  logic [1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, data_in, data_out;
  logic [AW-1:0]   addr;
  logic            wr_enable, rd_enable, busy;

  assign req_valid = {v_vld[1], v_vld[0]};
  assign req_we    = {v_we[1], v_we[0]};
  assign req_addr  = {v_addr[1], v_addr[0]};
  assign req_wdata = {v_wd[1], v_wd[0]};

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wr_enable(wr_enable), .rd_enable(rd_enable), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy)
  );

  // Synchronous memory with one-cycle read latency; cleared by reset so reads are always defined.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
      data_out <= '0;
    end else begin
      if (wr_enable) mem[addr] <= data_in;
      if (rd_enable) data_out <= mem[addr];
    end
  end

  typedef struct { logic we; logic [AW-1:0] a; logic [DW-1:0] d; int c; } op_t;
  typedef struct { int own; logic [DW-1:0] d; int c; } rsp_t;

  op_t  opq[$];
  rsp_t rq[$];
  int   acc_own[$];
  int   acc_cyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int free_cyc = 0;
  bit started = 0;
  int last_win = 1;
  logic [DW-1:0] ref_mem [16];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din, exp_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor and reference model: one operation at a time, round-robin on ties.
  always @(negedge clk) begin
    op_t e;
    rsp_t r;
    logic [1:0] er;
    int w;
    if (started) begin
      chk("en_exclusive", 32'(wr_enable & rd_enable), 32'd0);
      if (wr_enable | rd_enable) begin
        if (opq.size() == 0) fail("unexpected_enable");
        else begin
          e = opq.pop_front();
          chk("en_cycle", 32'(cyc), 32'(e.c));
          chk("wr_enable", 32'(wr_enable), 32'(e.we));
          chk("rd_enable", 32'(rd_enable), 32'(!e.we));
          exp_addr = e.a;
          exp_din  = e.d;
        end
      end
      while (opq.size() > 0 && opq[0].c < cyc) begin
        fail("missing_enable");
        void'(opq.pop_front());
      end
      chk("addr", 32'(addr), 32'(exp_addr));
      chk("data_in", 32'(data_in), 32'(exp_din));
      if (rsp_valid != 2'b00) begin
        if (rq.size() == 0) fail("unexpected_rsp");
        else begin
          r = rq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), (r.own == 1) ? 32'd2 : 32'd1);
          chk("rsp_cycle", 32'(cyc), 32'(r.c));
          exp_rdata = r.d;
        end
      end
      while (rq.size() > 0 && rq[0].c < cyc) begin
        fail("missing_rsp");
        void'(rq.pop_front());
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      chk("busy", 32'(busy), 32'(cyc < free_cyc));
      er = 2'b00;
      if (!rst && cyc >= free_cyc) begin
        if (req_valid == 2'b11) er = (last_win == 1) ? 2'b01 : 2'b10;
        else er = req_valid;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      if (er != 2'b00) begin
        w = er[1] ? 1 : 0;
        last_win = w;
        acc_own.push_back(w);
        acc_cyc.push_back(cyc);
        opq.push_back('{we: v_we[w], a: v_addr[w], d: v_wd[w], c: cyc + 1});
        if (v_we[w]) begin
          ref_mem[v_addr[w]] = v_wd[w];
          free_cyc = cyc + 2;
        end else begin
          rq.push_back('{own: w, d: ref_mem[v_addr[w]], c: cyc + 3});
          free_cyc = cyc + 4;
        end
      end
    end
    if (rst) begin
      started = 1;
      opq.delete();
      rq.delete();
      last_win = 1;
      free_cyc = cyc + 1;
      exp_addr = '0;
      exp_din = '0;
      exp_rdata = '0;
      for (int k = 0; k < 16; k++) ref_mem[k] = '0;
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the transfer.
  task automatic drive(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit may_drop);
    bit done = 0;
    int n = 0;
    v_vld[i] = 1'b1; v_we[i] = we; v_addr[i] = a; v_wd[i] = d;
    while (!done) begin
      @(negedge clk);
      done = req_ready[i];
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        fail("accept_timeout");
        done = 1;
      end else if (!done && may_drop && $urandom_range(0, 5) == 0) begin
        done = 1;
      end
    end
    v_vld[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((opq.size() > 0 || rq.size() > 0 || cyc < free_cyc + 1) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) fail("idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v_vld[i] = 1'b0; v_we[i] = 1'b0; v_addr[i] = '0; v_wd[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write then read back on requester 0.
    drive(0, 1'b1, 4'h3, 8'hA5, 0);
    drive(0, 1'b0, 4'h3, 8'h00, 0);
    wait_idle();

    // Tie out of reset: requester 0 first.
    do_reset();
    acc_own.delete(); acc_cyc.delete();
    fork
      drive(0, 1'b0, 4'h1, 8'h11, 0);
      drive(1, 1'b0, 4'h2, 8'h22, 0);
    join
    wait_idle();
    chk("tie_size", 32'(acc_own.size()), 32'd2);
    if (acc_own.size() == 2) begin
      chk("tie_first", 32'(acc_own[0]), 32'd0);
      chk("tie_second", 32'(acc_own[1]), 32'd1);
    end

    // Sustained contention must alternate.
    acc_own.delete(); acc_cyc.delete();
    fork
      repeat (4) drive(0, 1'($urandom), 4'($urandom), 8'($urandom), 0);
      repeat (4) drive(1, 1'($urandom), 4'($urandom), 8'($urandom), 0);
    join
    wait_idle();
    chk("cont_size", 32'(acc_own.size()), 32'd8);
    for (int k = 1; k < acc_own.size(); k++)
      chk("cont_alternate", 32'(acc_own[k]), 32'(1 - acc_own[k-1]));

    // Requester 1 alone, back-to-back writes every 2 cycles.
    acc_own.delete(); acc_cyc.delete();
    repeat (4) drive(1, 1'b1, 4'($urandom), 8'($urandom), 0);
    wait_idle();
    chk("single_size", 32'(acc_cyc.size()), 32'd4);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("single_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);

    // Reset while the read sits in WAIT: no response, then a normal tie.
    drive(0, 1'b0, 4'h5, 8'h00, 0);
    @(posedge clk); #1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    acc_own.delete(); acc_cyc.delete();
    fork
      drive(0, 1'b1, 4'h7, 8'h5A, 0);
      drive(1, 1'b0, 4'h7, 8'h00, 0);
    join
    wait_idle();
    chk("post_reset_size", 32'(acc_own.size()), 32'd2);
    if (acc_own.size() == 2) chk("post_reset_first", 32'(acc_own[0]), 32'd0);

    // Address extremes must not alias.
    drive(0, 1'b1, 4'hF, 8'h3C, 0);
    drive(1, 1'b1, 4'h0, 8'hC3, 0);
    drive(0, 1'b0, 4'hF, 8'h00, 0);
    drive(1, 1'b0, 4'h0, 8'h00, 0);
    wait_idle();

    // Random traffic with idle gaps and abandoned requests.
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        drive(0, 1'($urandom), 4'($urandom), 8'($urandom), 1);
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        drive(1, 1'($urandom), 4'($urandom), 8'($urandom), 1);
      end
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
